// File: rtl/data_mem_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_unit_pkg                                               |
// | Purpose  : Shared pipeline definitions: mem_size encodings, the load       |
// |            formatting control bundle and the store byte-lane mask helper.  |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package data_mem_unit_pkg;

  // Access size encodings, shared by the decoder, EX/MEM register and data memory
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // Request-cycle fields carried alongside the raw read word
  typedef struct packed {
    logic [1:0] size;
    logic       sz_ex;
    logic [1:0] off;
  } ld_ctl_t;

  // Little-endian byte-lane enables for an aligned store
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << off;
      SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_unit_if                                                |
// | Purpose  : EX/MEM-to-data-memory bus. The pipeline (master) issues         |
// |            load/store requests; the memory (slave) returns formatted data. |
// | Ports    : wr_en_in, rd_en_in, mem_size_in, sz_ex_in, addr_in, wdata_in,   |
// |            stall (master->slave); rdata_out, rvalid_out, misalign_out      |
// |            (slave->master)                                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface data_mem_unit_if;
  logic        wr_en_in;
  logic        rd_en_in;
  logic [1:0]  mem_size_in;
  logic        sz_ex_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rvalid_out;
  logic        misalign_out;

  modport master (
    output wr_en_in, rd_en_in, mem_size_in, sz_ex_in, addr_in, wdata_in, stall,
    input  rdata_out, rvalid_out, misalign_out
  );

  modport slave (
    input  wr_en_in, rd_en_in, mem_size_in, sz_ex_in, addr_in, wdata_in, stall,
    output rdata_out, rvalid_out, misalign_out
  );
endinterface
`default_nettype wire

// File: rtl/dmem_byte_lanes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_byte_lanes                                                 |
// | Purpose  : Word-addressed RAM built from four independent byte lanes with  |
// |            per-lane write enables and a registered (synchronous) read.     |
// | Ports    : clk      - clock                                                |
// |            i_we     - per-lane write enables                               |
// |            i_addr   - word index (shared by read and write)                |
// |            i_wdata  - write data, lane k on bits [8k+7:8k]                 |
// |            i_re     - read enable; read register holds when low            |
// |            o_rdata  - registered read word                                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_byte_lanes #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic [3:0]    i_we,
  input  wire logic [AW-1:0] i_addr,
  input  wire logic [31:0]   i_wdata,
  input  wire logic          i_re,
  output logic [31:0]        o_rdata
);

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_q;

    // Contents are deliberately not reset so a pipeline reset preserves memory
    always_ff @(posedge clk) begin
      if (i_we[k]) begin
        r_mem[i_addr] <= i_wdata[8*k +: 8];
      end
      if (i_re) begin
        r_q <= r_mem[i_addr];
      end
    end

    assign o_rdata[8*k +: 8] = r_q;
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_unit                                                   |
// | Purpose  : MEM-stage data memory: alignment check, little-endian byte/     |
// |            half/word stores, 1-cycle loads with sign/zero extension.       |
// | Ports    : clk - clock                                                     |
// |            rst - synchronous active-low reset                              |
// |            bus - data_mem_unit_if.slave request/response bus               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  wire logic      clk,
  input  wire logic      rst,
  data_mem_unit_if.slave bus
);

  localparam int c_AW = $clog2(DEPTH);

  logic          w_req;
  logic          w_misalign;
  logic          w_store;
  logic          w_load;
  logic [3:0]    w_we;
  logic [31:0]   w_wdata;
  logic [c_AW-1:0] w_idx;
  logic [31:0]   w_raw;
  logic [31:0]   w_shift;
  logic [31:0]   w_fmt;

  logic          r_rvalid;
  logic          r_misalign;
  ld_ctl_t       r_ctl;

  // Upper address bits are ignored so accesses wrap within DEPTH words
  assign w_idx = bus.addr_in[c_AW+1:2];

  assign w_req = bus.wr_en_in | bus.rd_en_in;

  always_comb begin
    w_misalign = 1'b0;
    case (bus.mem_size_in)
      SZ_BYTE: w_misalign = 1'b0;
      SZ_HALF: w_misalign = bus.addr_in[0];
      SZ_WORD: w_misalign = (bus.addr_in[1:0] != 2'b00);
      default: w_misalign = 1'b1;
    endcase
    w_misalign = w_misalign & w_req;
  end

  // Stores win over a simultaneous load; a misaligned store writes no lane at all
  assign w_store = rst & ~bus.stall & bus.wr_en_in & ~w_misalign;
  assign w_load  = rst & ~bus.stall & bus.rd_en_in & ~bus.wr_en_in & ~w_misalign;

  assign w_we = w_store ? lane_mask(bus.mem_size_in, bus.addr_in[1:0]) : 4'b0000;

  // Replicate right-aligned store data so every enabled lane sees its byte
  always_comb begin
    case (bus.mem_size_in)
      SZ_BYTE: w_wdata = {4{bus.wdata_in[7:0]}};
      SZ_HALF: w_wdata = {2{bus.wdata_in[15:0]}};
      default: w_wdata = bus.wdata_in;
    endcase
  end

  dmem_byte_lanes #(
    .DEPTH (DEPTH),
    .AW    (c_AW)
  ) u_lanes (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .i_re    (w_load),
    .o_rdata (w_raw)
  );

  // The read register only advances on an accepted load, so together with the
  // held control fields the formatted output is frozen across stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rvalid   <= 1'b0;
      r_misalign <= 1'b0;
      r_ctl      <= '0;
    end else if (!bus.stall) begin
      r_rvalid   <= w_load;
      r_misalign <= w_misalign;
      if (w_load) begin
        r_ctl.size  <= bus.mem_size_in;
        r_ctl.sz_ex <= bus.sz_ex_in;
        r_ctl.off   <= bus.addr_in[1:0];
      end
    end
  end

  // Move the addressed byte/half down to bit 0, then extend
  assign w_shift = w_raw >> {r_ctl.off, 3'b000};

  always_comb begin
    case (r_ctl.size)
      SZ_BYTE: w_fmt = {{24{r_ctl.sz_ex & w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: w_fmt = {{16{r_ctl.sz_ex & w_shift[15]}}, w_shift[15:0]};
      default: w_fmt = w_raw;
    endcase
  end

  assign bus.rdata_out    = r_rvalid ? w_fmt : 32'h0;
  assign bus.rvalid_out   = r_rvalid;
  assign bus.misalign_out = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_unit                                                |
// | Purpose  : Self-checking bench for data_mem_unit. Each driven cycle pushes |
// |            its expected response; a monitor pops and compares after the    |
// |            following rising edge.                                          |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_data_mem_unit;
  import data_mem_unit_pkg::*;

  typedef struct {
    logic        chk;
    logic        chk_d;
    logic        rv;
    logic        mis;
    logic [31:0] d;
    string       name;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  exp_t q[$];

  data_mem_unit_if bus();

  data_mem_unit #(.DEPTH(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t E(input string n, input logic chk_d, input logic rv,
                             input logic mis, input logic [31:0] d);
    exp_t e;
    e.chk = 1'b1; e.chk_d = chk_d; e.rv = rv; e.mis = mis; e.d = d; e.name = n;
    return e;
  endfunction

  function automatic exp_t NOCHK();
    exp_t e;
    e.chk = 1'b0; e.chk_d = 1'b0; e.rv = 1'b0; e.mis = 1'b0; e.d = 32'h0; e.name = "none";
    return e;
  endfunction

  // Drive one request cycle and queue the response expected after its edge
  task automatic drive(input logic r, input logic st, input logic wr, input logic rd,
                       input logic [1:0] sz, input logic sx, input logic [31:0] a,
                       input logic [31:0] wd, input exp_t e);
    @(negedge clk);
    rst             = r;
    bus.stall       = st;
    bus.wr_en_in    = wr;
    bus.rd_en_in    = rd;
    bus.mem_size_in = sz;
    bus.sz_ex_in    = sx;
    bus.addr_in     = a;
    bus.wdata_in    = wd;
    q.push_back(e);
  endtask

  task automatic idle(input exp_t e);
    drive(1'b1, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, e);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                    input exp_t e);
    drive(1'b1, 1'b0, 1'b1, 1'b0, sz, 1'b0, a, wd, e);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a, input exp_t e);
    drive(1'b1, 1'b0, 1'b0, 1'b1, sz, sx, a, 32'h0, e);
  endtask

  // Monitor: compares the DUT response against the head of the scoreboard
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.chk) begin
        n_chk++;
        if (bus.rvalid_out !== e.rv || bus.misalign_out !== e.mis ||
            (e.chk_d && bus.rdata_out !== e.d)) begin
          $display("FAIL %s: got rvalid=%b misalign=%b rdata=%08h, want rvalid=%b misalign=%b rdata=%08h%s",
                   e.name, bus.rvalid_out, bus.misalign_out, bus.rdata_out,
                   e.rv, e.mis, e.d, e.chk_d ? "" : " (data not checked)");
        end else begin
          n_pass++;
        end
      end
    end
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b0;
    bus.stall = 1'b0; bus.wr_en_in = 1'b0; bus.rd_en_in = 1'b0;
    bus.mem_size_in = SZ_WORD; bus.sz_ex_in = 1'b0;
    bus.addr_in = 32'h0; bus.wdata_in = 32'h0;

    // Reset state
    drive(1'b0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, E("reset0", 1, 0, 0, 32'h0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, E("reset1", 1, 0, 0, 32'h0));

    // Word round trip
    st(SZ_WORD, 32'h10, 32'h8899AABB, E("st_word", 0, 0, 0, 32'h0));
    ld(SZ_WORD, 1'b0, 32'h10, E("ld_word", 1, 1, 0, 32'h8899AABB));

    // Byte / half extension
    ld(SZ_BYTE, 1'b1, 32'h11, E("ld_byte_sx", 1, 1, 0, 32'hFFFFFFAA));
    ld(SZ_BYTE, 1'b0, 32'h11, E("ld_byte_zx", 1, 1, 0, 32'h000000AA));
    ld(SZ_HALF, 1'b1, 32'h12, E("ld_half_sx", 1, 1, 0, 32'hFFFF8899));
    ld(SZ_BYTE, 1'b0, 32'h13, E("ld_byte3_zx", 1, 1, 0, 32'h00000088));

    // Halfword store ignores upper store-data bits
    st(SZ_HALF, 32'h12, 32'hFFFF1234, E("st_half", 0, 0, 0, 32'h0));
    ld(SZ_WORD, 1'b0, 32'h10, E("ld_after_half", 1, 1, 0, 32'h1234AABB));

    // Misaligned store: flag one cycle, memory untouched
    st(SZ_WORD, 32'h11, 32'hDEADBEEF, E("st_misalign", 0, 0, 1, 32'h0));
    idle(E("misalign_clears", 0, 0, 0, 32'h0));
    ld(SZ_WORD, 1'b0, 32'h10, E("ld_unchanged", 1, 1, 0, 32'h1234AABB));
    ld(SZ_HALF, 1'b0, 32'h13, E("ld_half_misalign", 1, 0, 1, 32'h0));
    ld(SZ_RSVD, 1'b0, 32'h10, E("ld_reserved", 1, 0, 1, 32'h0));

    // Store priority over a simultaneous load
    drive(1'b1, 1'b0, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h14, 32'hCAFEF00D,
          E("wr_rd_both", 0, 0, 0, 32'h0));
    ld(SZ_WORD, 1'b0, 32'h14, E("ld_priority", 1, 1, 0, 32'hCAFEF00D));

    // Byte store into top lane, signed byte load back
    st(SZ_BYTE, 32'h17, 32'h000000A5, E("st_byte", 0, 0, 0, 32'h0));
    ld(SZ_WORD, 1'b0, 32'h14, E("ld_after_byte", 1, 1, 0, 32'hA5FEF00D));
    ld(SZ_BYTE, 1'b1, 32'h17, E("ld_byte_top_sx", 1, 1, 0, 32'hFFFFFFA5));

    // Address wrap-around: 0x410 aliases word 0x10 for DEPTH=256
    ld(SZ_WORD, 1'b0, 32'h410, E("ld_wrap", 1, 1, 0, 32'h1234AABB));

    // Stall holds outputs and blocks a store
    ld(SZ_WORD, 1'b0, 32'h10, E("ld_pre_stall", 1, 1, 0, 32'h1234AABB));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h00000000,
            E("stall_hold", 1, 1, 0, 32'h1234AABB));
    end
    ld(SZ_WORD, 1'b0, 32'h10, E("ld_post_stall", 1, 1, 0, 32'h1234AABB));

    // Reset during a load discards it; memory survives
    drive(1'b0, 1'b0, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h0, E("ld_in_reset", 1, 0, 0, 32'h0));
    idle(E("post_reset", 0, 0, 0, 32'h0));
    ld(SZ_WORD, 1'b0, 32'h10, E("ld_after_reset", 1, 1, 0, 32'h1234AABB));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
